// File: rtl/sort_requester.sv
// rtl/sort_requester.sv - sorter traffic generator and result checker
// Issues LFSR or pattern operand words, waits for the sorter and checks order plus multiset.
module sort_requester #(
  parameter logic [31:0] SEED    = 32'h1,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        use_pattern_i,
  input  logic [31:0] pattern_i,
  output logic        start_clear_o,
  output logic [31:0] nums_o,
  input  logic        valid_i,
  input  logic [31:0] sorted_nums_i,
  output logic        busy_o,
  output logic [15:0] pass_cnt_o,
  output logic [15:0] fail_cnt_o,
  output logic        err_o,
  output logic        last_ok_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GEN   = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [9:0]  TMO_LAST  = 10'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] result;
  logic [9:0]  tmo_cnt;
  logic [3:0]  v;
  logic        mismatch;
  logic [3:0]  cnt_ops;
  logic [3:0]  cnt_res;
  logic        ordered;
  logic        hist_bad;
  logic        ok;
  logic        rec_en;
  logic        rec_ok;

  assign start_clear_o = (state == S_REQ) || (state == S_CHECK);
  assign busy_o        = (state != S_IDLE);

  // Galois step for x^32+x^22+x^2+x+1, shifting right
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    cnt_ops = 4'd0;
    cnt_res = 4'd0;
    ordered = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cnt_ops = cnt_ops + {3'b000, (nums_o[4*k +: 4] == v)};
      cnt_res = cnt_res + {3'b000, (result[4*k +: 4] == v)};
    end
    for (int k = 0; k < 7; k++) begin
      if (result[4*k +: 4] > result[4*(k+1) +: 4]) ordered = 1'b0;
    end
    hist_bad = (cnt_ops != cnt_res);
    ok       = !mismatch && !hist_bad && ordered;
  end

  always_comb begin
    rec_en = 1'b0;
    rec_ok = 1'b0;
    case (state)
      S_REQ:   rec_en = !valid_i && (tmo_cnt == TMO_LAST);
      S_CHECK: begin
        rec_en = (v == 4'd15);
        rec_ok = ok;
      end
      S_CLEAR: rec_en = valid_i && (tmo_cnt == TMO_LAST);
      default: rec_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      nums_o   <= 32'h0;
      lfsr     <= LFSR_INIT;
      tmo_cnt  <= 10'd0;
      result   <= 32'h0;
      v        <= 4'd0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i) state <= S_GEN;
        end
        S_GEN: begin
          // The issued word is the freshly stepped value, so SEED itself is never sent
          if (use_pattern_i) begin
            nums_o <= pattern_i;
          end else begin
            nums_o <= lfsr_next;
            lfsr   <= lfsr_next;
          end
          tmo_cnt <= 10'd0;
          state   <= S_REQ;
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 10'd1;
          if (valid_i) begin
            result   <= sorted_nums_i;
            v        <= 4'd0;
            mismatch <= 1'b0;
            state    <= S_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= 10'd0;
            state   <= S_CLEAR;
          end
        end
        S_CHECK: begin
          v <= v + 4'd1;
          if (hist_bad) mismatch <= 1'b1;
          if (v == 4'd15) begin
            tmo_cnt <= 10'd0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          tmo_cnt <= tmo_cnt + 10'd1;
          if (!valid_i) begin
            state <= run_i ? S_GEN : S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_cnt_o <= 16'h0;
      fail_cnt_o <= 16'h0;
      err_o      <= 1'b0;
      last_ok_o  <= 1'b0;
    end else if (rec_en) begin
      if (rec_ok) begin
        if (pass_cnt_o != 16'hFFFF) pass_cnt_o <= pass_cnt_o + 16'd1;
      end else begin
        if (fail_cnt_o != 16'hFFFF) fail_cnt_o <= fail_cnt_o + 16'd1;
      end
      err_o     <= err_o | !rec_ok;
      last_ok_o <= rec_ok;
    end
  end

endmodule

// File: tb/tb_sort_requester.sv
// tb/tb_sort_requester.sv - directed bench for sort_requester with a transaction-level model
module tb_sort_requester;

  localparam int SORT_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        use_pattern = 1'b1;
  logic [31:0] pattern = 32'h0;
  logic        start_clear_o;
  logic [31:0] nums_o;
  logic        srt_valid = 1'b0;
  logic [31:0] srt_data = 32'h0;
  logic        busy_o;
  logic [15:0] pass_cnt_o;
  logic [15:0] fail_cnt_o;
  logic        err_o;
  logic        last_ok_o;

  int          n_checks = 0;
  int          n_err = 0;

  sort_requester #(.SEED(32'h1), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .use_pattern_i(use_pattern),
    .pattern_i(pattern), .start_clear_o(start_clear_o), .nums_o(nums_o),
    .valid_i(srt_valid), .sorted_nums_i(srt_data), .busy_o(busy_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .err_o(err_o),
    .last_ok_o(last_ok_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sort_word(input logic [31:0] w);
    logic [3:0]  e [8];
    logic [3:0]  t;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) e[i] = w[4*i +: 4];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    r = 32'h0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = e[i];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_diff(input string name, input logic [31:0] a, input logic [31:0] b);
    n_checks++;
    if (a === b) begin
      n_err++;
      $display("FAIL %s: got %h expected a value different from %h", name, a, b);
    end
  endtask

  // Sorter stand-in: 0 = correct, 1 = fixed word, 2 = never valid
  int          srt_mode = 0;
  logic [31:0] fixed_resp = 32'h0;
  int          srt_lat = 0;

  always @(posedge clk) begin
    if (!start_clear_o) begin
      srt_valid <= 1'b0;
      srt_lat   <= 0;
    end else if (srt_mode != 2) begin
      if (srt_lat == SORT_LAT) begin
        srt_valid <= 1'b1;
        srt_data  <= (srt_mode == 0) ? sort_word(nums_o) : fixed_resp;
      end else begin
        srt_lat <= srt_lat + 1;
      end
    end
  end

  // Transaction-level model of the requester
  logic [31:0] m_lfsr = 32'h1;
  logic [31:0] cap_nums = 32'h0;
  logic [31:0] prev_nums = 32'h0;
  logic        have_prev = 1'b0;
  logic [31:0] first_nums = 32'h0;
  logic        resp_seen = 1'b0;
  logic [31:0] resp_word = 32'h0;
  logic        prev_sc = 1'b0;
  int          hi_cycles = 0;
  int          last_hi = 0;
  int          n_starts = 0;
  int          n_done = 0;
  int          exp_pass = 0;
  int          exp_fail = 0;
  logic        exp_err = 1'b0;
  logic        exp_last_ok = 1'b0;

  always @(negedge clk) begin
    logic [31:0] exp_nums;
    logic        t_ok;
    if (rst) begin
      m_lfsr = 32'h1; have_prev = 1'b0; prev_sc = 1'b0; resp_seen = 1'b0;
      n_starts = 0; n_done = 0; exp_pass = 0; exp_fail = 0;
      exp_err = 1'b0; exp_last_ok = 1'b0; hi_cycles = 0;
    end else begin
      if (start_clear_o && !prev_sc) begin
        if (use_pattern) begin
          exp_nums = pattern;
        end else begin
          m_lfsr   = lfsr_step(m_lfsr);
          exp_nums = m_lfsr;
          if (have_prev) check_diff("lfsr_words_differ", nums_o, prev_nums);
        end
        check("nums_issued", nums_o, exp_nums);
        if (n_starts == 0) first_nums = nums_o;
        prev_nums = nums_o; have_prev = 1'b1;
        cap_nums = exp_nums; resp_seen = 1'b0; hi_cycles = 0;
        n_starts++;
      end
      if (start_clear_o) begin
        hi_cycles++;
        check("nums_stable", nums_o, cap_nums);
        if (srt_valid && !resp_seen) begin
          resp_seen = 1'b1;
          resp_word = srt_data;
        end
      end
      if (!start_clear_o && prev_sc) begin
        t_ok = resp_seen && (resp_word == sort_word(cap_nums));
        if (t_ok) exp_pass = (exp_pass < 65535) ? exp_pass + 1 : exp_pass;
        else      exp_fail = (exp_fail < 65535) ? exp_fail + 1 : exp_fail;
        exp_err = exp_err | !t_ok;
        exp_last_ok = t_ok;
        last_hi = hi_cycles;
        n_done++;
      end
      check("pass_cnt", {16'h0, pass_cnt_o}, exp_pass);
      check("fail_cnt", {16'h0, fail_cnt_o}, exp_fail);
      check("err", {31'h0, err_o}, {31'h0, exp_err});
      check("last_ok", {31'h0, last_ok_o}, {31'h0, exp_last_ok});
      prev_sc = start_clear_o;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk); #1 run = 1'b1;
    @(negedge clk); #1 run = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    @(negedge clk);
    while (busy_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_start_clear", {31'h0, start_clear_o}, 32'h0);
    check("rst_nums", nums_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_pass", {16'h0, pass_cnt_o}, 32'h0);

    // Correct sort of a pattern
    use_pattern = 1'b1; pattern = 32'h0123_4567; srt_mode = 0;
    pulse_run();
    wait_idle(200);
    check("t1_nums", nums_o, 32'h0123_4567);
    check("t1_result", resp_word, 32'h7654_3210);
    check("t1_pass", {16'h0, pass_cnt_o}, 32'd1);
    check("t1_last_ok", {31'h0, last_ok_o}, 32'd1);
    check("t1_err", {31'h0, err_o}, 32'd0);
    check("t1_start_clear", {31'h0, start_clear_o}, 32'd0);

    // Out of order
    do_reset();
    srt_mode = 1; fixed_resp = 32'h7654_3201;
    pulse_run();
    wait_idle(200);
    check("t2_fail", {16'h0, fail_cnt_o}, 32'd1);
    check("t2_err", {31'h0, err_o}, 32'd1);
    check("t2_last_ok", {31'h0, last_ok_o}, 32'd0);

    // Sorted but not a permutation
    do_reset();
    srt_mode = 1; fixed_resp = 32'h7754_3210;
    pulse_run();
    wait_idle(200);
    check("t3_fail", {16'h0, fail_cnt_o}, 32'd1);
    check("t3_pass", {16'h0, pass_cnt_o}, 32'd0);

    // Sorter never answers
    do_reset();
    srt_mode = 2;
    pulse_run();
    wait_idle(300);
    check("t4_req_cycles", last_hi, 32'd64);
    check("t4_fail", {16'h0, fail_cnt_o}, 32'd1);
    check("t4_busy", {31'h0, busy_o}, 32'd0);

    // LFSR stream, 100 back-to-back transactions
    do_reset();
    srt_mode = 0; use_pattern = 1'b0;
    @(negedge clk); #1 run = 1'b1;
    begin
      int i = 0;
      while (n_starts < 100 && i < 5000) begin
        @(negedge clk);
        i++;
      end
    end
    check("t5_starts", n_starts, 32'd100);
    #1 run = 1'b0;
    wait_idle(200);
    check("t5_first_nums", first_nums, 32'h8020_0003);
    check("t5_pass", {16'h0, pass_cnt_o}, 32'd100);
    check("t5_err", {31'h0, err_o}, 32'd0);

    // Reset asserted in the middle of CHECK
    pulse_run();
    begin
      int i = 0;
      while (!(srt_valid && start_clear_o) && i < 200) begin
        @(negedge clk);
        i++;
      end
    end
    repeat (4) @(negedge clk);
    check("t6_in_check", {31'h0, start_clear_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_start_clear", {31'h0, start_clear_o}, 32'd0);
    check("t6_rst_pass", {16'h0, pass_cnt_o}, 32'd0);
    check("t6_rst_fail", {16'h0, fail_cnt_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 run = 1'b1; rst = 1'b0;
    begin
      int i = 0;
      while (n_starts < 1 && i < 50) begin
        @(negedge clk);
        i++;
      end
    end
    #1 run = 1'b0;
    check("t6_first_nums", first_nums, 32'h8020_0003);
    wait_idle(200);
    check("t6_pass", {16'h0, pass_cnt_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
